// File: rtl/alu_issue_scheduler.sv
// Reservation station + oldest-ready issue scheduler in front of the single-cycle ALU.
// Define ALU_RS_WAKEUP_BYPASS_EN to let a CDB broadcast wake and issue an entry in the same cycle.
module alu_issue_scheduler #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 6,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [OP_W-1:0]            in_op,
  input  logic [DATA_W-1:0]          in_v1,
  input  logic [DATA_W-1:0]          in_v2,
  input  logic [TAG_W-1:0]           in_q1,
  input  logic [TAG_W-1:0]           in_q2,
  input  logic                       in_w1,
  input  logic                       in_w2,
  input  logic [DATA_W-1:0]          in_imm,
  input  logic [DATA_W-1:0]          in_pc,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       rs_full,
  output logic [$clog2(DEPTH):0]     rs_count,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [DATA_W-1:0]          cdb_data,
  output logic [OP_W-1:0]            op_to_alu,
  output logic [DATA_W-1:0]          v1_to_alu,
  output logic [DATA_W-1:0]          v2_to_alu,
  output logic [DATA_W-1:0]          imm_to_alu,
  output logic [DATA_W-1:0]          pc_to_alu,
  output logic                       is_empty_to_alu,
  output logic [TAG_W-1:0]           tag_to_rob
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic              busy_reg [DEPTH];
  logic [OP_W-1:0]   op_reg   [DEPTH];
  logic [DATA_W-1:0] v1_reg   [DEPTH];
  logic [DATA_W-1:0] v2_reg   [DEPTH];
  logic [TAG_W-1:0]  q1_reg   [DEPTH];
  logic [TAG_W-1:0]  q2_reg   [DEPTH];
  logic              w1_reg   [DEPTH];
  logic              w2_reg   [DEPTH];
  logic [DATA_W-1:0] imm_reg  [DEPTH];
  logic [DATA_W-1:0] pc_reg   [DEPTH];
  logic [TAG_W-1:0]  tag_reg  [DEPTH];
  logic [IDX_W-1:0]  rank_reg [DEPTH];

  logic [CNT_W-1:0]  rs_count_reg, rs_count_next;
  logic              rs_full_reg;
  logic [OP_W-1:0]   op_out_reg;
  logic [DATA_W-1:0] v1_out_reg, v2_out_reg, imm_out_reg, pc_out_reg;
  logic [TAG_W-1:0]  tag_out_reg;
  logic              empty_out_reg;

  logic [DEPTH-1:0]  hit1, hit2, ready;
  logic              sel_found, free_found, accept;
  logic [IDX_W-1:0]  sel_idx, sel_rank, free_idx, disp_rank;
  logic [DATA_W-1:0] iss_v1, iss_v2, disp_v1, disp_v2;
  logic              disp_hit1, disp_hit2;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ready
      assign hit1[gi] = busy_reg[gi] && w1_reg[gi] && cdb_valid && (q1_reg[gi] == cdb_tag);
      assign hit2[gi] = busy_reg[gi] && w2_reg[gi] && cdb_valid && (q2_reg[gi] == cdb_tag);
`ifdef ALU_RS_WAKEUP_BYPASS_EN
      assign ready[gi] = busy_reg[gi] && (!w1_reg[gi] || hit1[gi]) && (!w2_reg[gi] || hit2[gi]);
`else
      assign ready[gi] = busy_reg[gi] && !w1_reg[gi] && !w2_reg[gi];
`endif
    end
  endgenerate

  // Ranks are unique among busy entries, so the strict compare picks exactly the oldest ready one.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_rank   = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!sel_found || rank_reg[i] < sel_rank)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_rank  = rank_reg[i];
      end
      if (!busy_reg[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    iss_v1 = v1_reg[sel_idx];
    iss_v2 = v2_reg[sel_idx];
`ifdef ALU_RS_WAKEUP_BYPASS_EN
    if (hit1[sel_idx]) iss_v1 = cdb_data;
    if (hit2[sel_idx]) iss_v2 = cdb_data;
`endif
  end

  assign accept        = in_valid && !rs_full_reg && free_found;
  assign disp_hit1     = in_w1 && cdb_valid && (in_q1 == cdb_tag);
  assign disp_hit2     = in_w2 && cdb_valid && (in_q2 == cdb_tag);
  assign disp_v1       = disp_hit1 ? cdb_data : in_v1;
  assign disp_v2       = disp_hit2 ? cdb_data : in_v2;
  assign disp_rank     = IDX_W'(rs_count_reg - CNT_W'(sel_found));
  assign rs_count_next = rs_count_reg + CNT_W'(accept) - CNT_W'(sel_found);

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (!rst || flush) begin
          busy_reg[gi] <= 1'b0;
        end else begin
          if (sel_found && sel_idx == IDX_W'(gi)) begin
            busy_reg[gi] <= 1'b0;
          end else if (sel_found && busy_reg[gi] && rank_reg[gi] > sel_rank) begin
            rank_reg[gi] <= rank_reg[gi] - IDX_W'(1);
          end
          if (hit1[gi]) begin
            v1_reg[gi] <= cdb_data;
            w1_reg[gi] <= 1'b0;
          end
          if (hit2[gi]) begin
            v2_reg[gi] <= cdb_data;
            w2_reg[gi] <= 1'b0;
          end
          // A free entry has no hits or issue, so dispatch never collides with the updates above.
          if (accept && free_idx == IDX_W'(gi)) begin
            busy_reg[gi] <= 1'b1;
            op_reg[gi]   <= in_op;
            v1_reg[gi]   <= disp_v1;
            v2_reg[gi]   <= disp_v2;
            q1_reg[gi]   <= in_q1;
            q2_reg[gi]   <= in_q2;
            w1_reg[gi]   <= in_w1 && !disp_hit1;
            w2_reg[gi]   <= in_w2 && !disp_hit2;
            imm_reg[gi]  <= in_imm;
            pc_reg[gi]   <= in_pc;
            tag_reg[gi]  <= in_tag;
            rank_reg[gi] <= disp_rank;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      rs_count_reg  <= '0;
      rs_full_reg   <= 1'b0;
      empty_out_reg <= 1'b1;
      op_out_reg    <= '0;
      v1_out_reg    <= '0;
      v2_out_reg    <= '0;
      imm_out_reg   <= '0;
      pc_out_reg    <= '0;
      tag_out_reg   <= '0;
    end else if (flush) begin
      rs_count_reg  <= '0;
      rs_full_reg   <= 1'b0;
      empty_out_reg <= 1'b1;
    end else begin
      rs_count_reg  <= rs_count_next;
      rs_full_reg   <= (rs_count_next == CNT_W'(DEPTH));
      empty_out_reg <= !sel_found;
      if (sel_found) begin
        op_out_reg  <= op_reg[sel_idx];
        v1_out_reg  <= iss_v1;
        v2_out_reg  <= iss_v2;
        imm_out_reg <= imm_reg[sel_idx];
        pc_out_reg  <= pc_reg[sel_idx];
        tag_out_reg <= tag_reg[sel_idx];
      end
    end
  end

  assign rs_full         = rs_full_reg;
  assign rs_count        = rs_count_reg;
  assign is_empty_to_alu = empty_out_reg;
  assign op_to_alu       = op_out_reg;
  assign v1_to_alu       = v1_out_reg;
  assign v2_to_alu       = v2_out_reg;
  assign imm_to_alu      = imm_out_reg;
  assign pc_to_alu       = pc_out_reg;
  assign tag_to_rob      = tag_out_reg;

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Scoreboard bench for alu_issue_scheduler: an age-ordered queue model predicts every cycle's outputs.
// Honours ALU_RS_WAKEUP_BYPASS_EN the same way as the design.
module tb_alu_issue_scheduler;
  localparam int DEPTH = 8, TAG_W = 4, OP_W = 6, DATA_W = 32;
`ifdef ALU_RS_WAKEUP_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_w1, in_w2, cdb_valid;
  logic [OP_W-1:0] in_op;
  logic [DATA_W-1:0] in_v1, in_v2, in_imm, in_pc, cdb_data;
  logic [TAG_W-1:0] in_q1, in_q2, in_tag, cdb_tag;
  logic rs_full, is_empty_to_alu;
  logic [$clog2(DEPTH):0] rs_count;
  logic [OP_W-1:0] op_to_alu;
  logic [DATA_W-1:0] v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu;
  logic [TAG_W-1:0] tag_to_rob;

  always #5 clk = ~clk;

  alu_issue_scheduler #(.DEPTH(DEPTH), .TAG_W(TAG_W), .OP_W(OP_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_op(in_op),
    .in_v1(in_v1), .in_v2(in_v2), .in_q1(in_q1), .in_q2(in_q2), .in_w1(in_w1), .in_w2(in_w2),
    .in_imm(in_imm), .in_pc(in_pc), .in_tag(in_tag), .rs_full(rs_full), .rs_count(rs_count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .op_to_alu(op_to_alu), .v1_to_alu(v1_to_alu), .v2_to_alu(v2_to_alu),
    .imm_to_alu(imm_to_alu), .pc_to_alu(pc_to_alu),
    .is_empty_to_alu(is_empty_to_alu), .tag_to_rob(tag_to_rob)
  );

  typedef struct {
    logic [OP_W-1:0] op;
    logic [DATA_W-1:0] v1, v2, imm, pc;
    logic [TAG_W-1:0] q1, q2, tag;
    bit w1, w2;
  } ent_t;

  typedef struct {
    bit empty, chk_data, full;
    int count;
    logic [OP_W-1:0] op;
    logic [DATA_W-1:0] v1, v2, imm, pc;
    logic [TAG_W-1:0] tag;
  } exp_t;

  ent_t rs_q[$];     // oldest first
  exp_t sb_q[$];
  exp_t last_out;
  int compared = 0;
  int mismatched = 0;

  function automatic bit op_hit(bit w, logic [TAG_W-1:0] q);
    return w && cdb_valid && (q == cdb_tag);
  endfunction

  function automatic bit is_ready(ent_t x);
    if (BYPASS) return (!x.w1 || op_hit(x.w1, x.q1)) && (!x.w2 || op_hit(x.w2, x.q2));
    return !x.w1 && !x.w2;
  endfunction

  // Predict the outputs that will be visible after the coming clock edge.
  task automatic model_step();
    exp_t e;
    ent_t x;
    int pick;
    bit full_now;
    e = last_out;
    e.chk_data = 1'b0;
    if (!rst) begin
      rs_q.delete();
      e = '{empty: 1'b1, chk_data: 1'b1, full: 1'b0, count: 0, op: '0, v1: '0, v2: '0,
            imm: '0, pc: '0, tag: '0};
    end else if (flush) begin
      rs_q.delete();
      e.empty = 1'b1; e.count = 0; e.full = 1'b0;
    end else begin
      full_now = (rs_q.size() == DEPTH);
      pick = -1;
      for (int i = 0; i < rs_q.size(); i++)
        if (is_ready(rs_q[i])) begin pick = i; break; end
      e.empty = 1'b1;
      if (pick >= 0) begin
        x = rs_q[pick];
        e.empty = 1'b0; e.chk_data = 1'b1;
        e.op = x.op; e.imm = x.imm; e.pc = x.pc; e.tag = x.tag;
        e.v1 = x.w1 ? cdb_data : x.v1;
        e.v2 = x.w2 ? cdb_data : x.v2;
        rs_q.delete(pick);
      end
      for (int i = 0; i < rs_q.size(); i++) begin
        if (op_hit(rs_q[i].w1, rs_q[i].q1)) begin rs_q[i].v1 = cdb_data; rs_q[i].w1 = 1'b0; end
        if (op_hit(rs_q[i].w2, rs_q[i].q2)) begin rs_q[i].v2 = cdb_data; rs_q[i].w2 = 1'b0; end
      end
      if (in_valid && !full_now) begin
        x.op = in_op; x.imm = in_imm; x.pc = in_pc; x.tag = in_tag; x.q1 = in_q1; x.q2 = in_q2;
        x.w1 = in_w1 && !op_hit(in_w1, in_q1);
        x.w2 = in_w2 && !op_hit(in_w2, in_q2);
        x.v1 = op_hit(in_w1, in_q1) ? cdb_data : in_v1;
        x.v2 = op_hit(in_w2, in_q2) ? cdb_data : in_v2;
        rs_q.push_back(x);
      end
      e.count = rs_q.size();
      e.full = (rs_q.size() == DEPTH);
    end
    last_out = e;
    sb_q.push_back(e);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; cdb_valid = 1'b0;
    in_w1 = 1'b0; in_w2 = 1'b0;
  endtask

  task automatic disp(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] v1,
                      input bit w1, input logic [TAG_W-1:0] q1, input logic [DATA_W-1:0] v2,
                      input bit w2, input logic [TAG_W-1:0] q2, input logic [TAG_W-1:0] tag);
    in_valid = 1'b1; in_op = op; in_v1 = v1; in_w1 = w1; in_q1 = q1;
    in_v2 = v2; in_w2 = w2; in_q2 = q2; in_tag = tag;
    in_imm = $urandom; in_pc = $urandom;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one scoreboard record per cycle, compared away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("is_empty", 32'(is_empty_to_alu), 32'(e.empty));
      chk("rs_count", 32'(rs_count), 32'(e.count));
      chk("rs_full", 32'(rs_full), 32'(e.full));
      if (e.chk_data) begin
        chk("op", 32'(op_to_alu), 32'(e.op));
        chk("v1", v1_to_alu, e.v1);
        chk("v2", v2_to_alu, e.v2);
        chk("imm", imm_to_alu, e.imm);
        chk("pc", pc_to_alu, e.pc);
        chk("tag", 32'(tag_to_rob), 32'(e.tag));
        if (!e.empty)
          $display("issue tag=%0d op=%0d v1=%0h v2=%0h count=%0d", tag_to_rob, op_to_alu,
                   v1_to_alu, v2_to_alu, rs_count);
      end
    end
  end

  initial begin
    idle();
    in_op = '0; in_v1 = '0; in_v2 = '0; in_q1 = '0; in_q2 = '0; in_imm = '0; in_pc = '0;
    in_tag = '0; cdb_tag = '0; cdb_data = '0;
    // reset for two cycles
    rst = 1'b0; cyc(); cyc();
    idle(); cyc();
    // simple ready op
    disp(6'd1, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 4'd3); cyc();
    idle(); cyc(); cyc();
    // older waiting op overtaken by younger ready op, then woken
    disp(6'd2, 32'd0, 1'b1, 4'd9, 32'd1, 1'b0, 4'd0, 4'd1); cyc();
    disp(6'd3, 32'd2, 1'b0, 4'd0, 32'd3, 1'b0, 4'd0, 4'd2); cyc();
    idle(); cyc();
    cdb(4'd9, 32'h10); cyc();
    idle(); cyc(); cyc(); cyc();
    // fill to full, ninth ignored, single broadcast drains in order
    for (int i = 0; i < DEPTH; i++) begin
      disp(6'(i + 4), 32'd0, 1'b1, 4'd4, 32'(i), 1'b0, 4'd0, 4'(i + 5)); cyc();
    end
    disp(6'd20, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 4'd15); cyc();
    idle(); cdb(4'd4, 32'h44); cyc();
    idle(); for (int i = 0; i < DEPTH + 2; i++) cyc();
    // dispatch captures a same-cycle broadcast
    disp(6'd9, 32'd3, 1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 4'd7); cdb(4'd6, 32'hAB); cyc();
    idle(); cyc(); cyc();
    // flush against four waiting entries with coincident dispatch and broadcast
    for (int i = 0; i < 4; i++) begin
      disp(6'(i + 30), 32'd0, 1'b1, 4'd7, 32'd0, 1'b1, 4'd7, 4'(i)); cyc();
    end
    disp(6'd40, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 4'd9); cdb(4'd7, 32'h77); flush = 1'b1; cyc();
    idle(); cdb(4'd7, 32'h78); cyc();
    idle(); cyc(); cyc();
    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      idle();
      if ($urandom_range(99) < 60)
        disp(6'($urandom), $urandom, 1'($urandom_range(99) < 40), 4'($urandom_range(7)),
             $urandom, 1'($urandom_range(99) < 40), 4'($urandom_range(7)), 4'($urandom));
      if ($urandom_range(99) < 45) cdb(4'($urandom_range(7)), $urandom);
      if ($urandom_range(99) < 2) flush = 1'b1;
      if ($urandom_range(299) < 2) rst = 1'b0;
      cyc();
    end
    idle(); cyc(); cyc();
    @(negedge clk);
    #1;
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
